// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM-side frame buffer blocks.
//   wr_state_t      : writer FSM states
//   SOF_BIT         : start-of-frame flag position in a Sobel FIFO word
//   DEF_FRAME_WORDS : default pixels per frame (640x480)
//   DEF_BURST_LEN   : default words per SDRAM burst
package sdram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        REQ,
        BURST
    } wr_state_t;

    localparam int SOF_BIT         = 16;
    localparam int DEF_FRAME_WORDS = 307200;
    localparam int DEF_BURST_LEN   = 256;

endpackage

// File: rtl/frame_addr_gen.sv
// Frame-buffer offset tracker for the Sobel SDRAM writer.
// Ports:
//   clk, rst     : clock, async active-high reset
//   prime        : word 0 of a new burst is on the FIFO output this cycle
//   sof          : start-of-frame flag of the word on the FIFO output
//   advance      : last word of the current burst is being taken
//   realign_req  : start-of-frame seen mid-burst; next burst restarts the frame
//   burst_addr   : start address of the burst being requested
//   frame_done   : one-cycle pulse after the final burst of a frame
module frame_addr_gen
    import sdram_pkg::*;
#(
    parameter int BURST_LEN   = DEF_BURST_LEN,
    parameter int FRAME_WORDS = DEF_FRAME_WORDS,
    parameter int ADDR_WIDTH  = 24,
    parameter int FRAME_BASE  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  prime,
    input  logic                  sof,
    input  logic                  advance,
    input  logic                  realign_req,
    output logic [ADDR_WIDTH-1:0] burst_addr,
    output logic                  frame_done
);

    localparam logic [ADDR_WIDTH-1:0] FW_A   = ADDR_WIDTH'(FRAME_WORDS);
    localparam logic [ADDR_WIDTH-1:0] BL_A   = ADDR_WIDTH'(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(FRAME_BASE);

    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] offset_adv;
    logic                  realign;
    logic                  wrap;

    // The end-of-frame wrap is deferred to the next burst start so that
    // a frame-aligned SOF and a plain wrap take the same path.
    assign wrap       = sof | realign | (offset == FW_A);
    assign offset_adv = offset + BL_A;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            offset     <= '0;
            realign    <= 1'b0;
            burst_addr <= BASE_A;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (prime) begin
                offset     <= wrap ? '0 : offset;
                burst_addr <= BASE_A + (wrap ? '0 : offset);
                realign    <= 1'b0;
            end
            if (advance) begin
                offset     <= offset_adv;
                frame_done <= (offset_adv == FW_A);
            end
            // prime and realign_req are never active together (PRIME vs BURST)
            if (realign_req)
                realign <= 1'b1;
        end
    end

endmodule

// File: rtl/sobel_fifo_sdram_writer.sv
// Drains the Sobel output FIFO into the SDRAM frame buffer as fixed-length
// write bursts.
// Ports:
//   clk, rst      : SDRAM-domain clock (also FIFO read clock), async active-high reset
//   enable        : allows new bursts to start
//   data_count_r  : FIFO read-side occupancy
//   fifo_dout     : FIFO word {sof, pixel[15:0]}, valid the cycle after a pop
//   rd_fifo       : FIFO pop strobe
//   wr_req/wr_ack : burst request / one-cycle grant
//   wr_addr       : burst start word address
//   wr_take       : controller consumes wr_data this cycle
//   wr_data       : pixel currently on the FIFO output
//   busy          : FSM not idle
//   frame_done    : pulse after the last word of a frame
//   sync_err      : pulse after a start-of-frame flag found mid-burst
module sobel_fifo_sdram_writer
    import sdram_pkg::*;
#(
    parameter int BURST_LEN   = DEF_BURST_LEN,
    parameter int FRAME_WORDS = DEF_FRAME_WORDS,
    parameter int ADDR_WIDTH  = 24,
    parameter int FRAME_BASE  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [9:0]            data_count_r,
    input  logic [16:0]           fifo_dout,
    output logic                  rd_fifo,
    output logic                  wr_req,
    input  logic                  wr_ack,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic                  wr_take,
    output logic [15:0]           wr_data,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  sync_err
);

    localparam int                CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0]  LAST   = CNT_W'(BURST_LEN - 1);
    localparam logic [10:0]       BL_CNT = 11'(BURST_LEN);

    wr_state_t        state, state_nxt;
    logic [CNT_W-1:0] word_cnt;
    logic             start;
    logic             last_take;
    logic             mid_sof;

    assign start   = enable && ({1'b0, data_count_r} >= BL_CNT);
    assign wr_req  = (state == REQ);
    assign busy    = (state != IDLE);
    assign wr_data = fifo_dout[15:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            word_cnt <= '0;
            sync_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            sync_err <= mid_sof;
            if (state == REQ && wr_ack)
                word_cnt <= '0;
            else if (state == BURST && wr_take)
                word_cnt <= word_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        rd_fifo   = 1'b0;
        last_take = 1'b0;
        mid_sof   = 1'b0;
        case (state)
            IDLE: begin
                // rst gate keeps the first pop quiet while reset is held
                if (start && !rst) begin
                    rd_fifo   = 1'b1;
                    state_nxt = PRIME;
                end
            end
            PRIME: state_nxt = REQ;
            REQ: begin
                if (wr_ack)
                    state_nxt = BURST;
            end
            BURST: begin
                if (wr_take) begin
                    mid_sof = fifo_dout[SOF_BIT] && (word_cnt != '0);
                    if (word_cnt == LAST) begin
                        // word 0 was popped in IDLE, so the last take needs no pop
                        last_take = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        rd_fifo = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    frame_addr_gen #(
        .BURST_LEN   (BURST_LEN),
        .FRAME_WORDS (FRAME_WORDS),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .FRAME_BASE  (FRAME_BASE)
    ) u_addr (
        .clk         (clk),
        .rst         (rst),
        .prime       (state == PRIME),
        .sof         (fifo_dout[SOF_BIT]),
        .advance     (last_take),
        .realign_req (mid_sof),
        .burst_addr  (wr_addr),
        .frame_done  (frame_done)
    );

endmodule

// File: tb/tb_sobel_fifo_sdram_writer.sv
`timescale 1ns/1ps
module tb_sobel_fifo_sdram_writer;

    localparam int            BL   = 256;
    localparam int            FW   = 2048;   // 8 bursts per frame keeps runtime short
    localparam int            AW   = 24;
    localparam logic [AW-1:0] BASE = 24'h10_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable;
    logic [9:0]    data_count_r;
    logic [16:0]   fifo_dout = '0;
    logic          rd_fifo;
    logic          wr_req;
    logic          wr_ack;
    logic [AW-1:0] wr_addr;
    logic          wr_take;
    logic [15:0]   wr_data;
    logic          busy;
    logic          frame_done;
    logic          sync_err;

    sobel_fifo_sdram_writer #(
        .BURST_LEN(BL), .FRAME_WORDS(FW), .ADDR_WIDTH(AW), .FRAME_BASE(32'h0010_0000)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .data_count_r(data_count_r),
        .fifo_dout(fifo_dout), .rd_fifo(rd_fifo), .wr_req(wr_req), .wr_ack(wr_ack),
        .wr_addr(wr_addr), .wr_take(wr_take), .wr_data(wr_data), .busy(busy),
        .frame_done(frame_done), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- FIFO model (show-ahead off: data one cycle after pop)
    logic [16:0] mem [0:4095];
    int          wp = 0;
    int          rp = 0;
    logic        fifo_flush = 1'b0;

    assign data_count_r = 10'(wp - rp);

    always @(posedge clk) begin
        if (fifo_flush)
            rp <= wp;
        else if (rd_fifo) begin
            fifo_dout <= mem[rp % 4096];
            rp        <= rp + 1;
        end
    end

    // ---------------- scoreboard queues
    logic [AW-1:0] exp_addr[$];
    logic [15:0]   exp_data[$];
    int            exp_fd[$];
    int            exp_se[$];
    logic [15:0]   pix = '0;

    task automatic push_word(input bit sof);
        mem[wp % 4096] = {sof, pix};
        exp_data.push_back(pix);
        pix++;
        wp++;
    endtask

    task automatic push_burst(input int sof_pos, input logic [AW-1:0] addr);
        exp_addr.push_back(addr);
        for (int i = 0; i < BL; i++)
            push_word(i == sof_pos);
    endtask

    // ---------------- SDRAM controller model
    int unsigned ack_delay = 0;
    int unsigned gap_min   = 0;
    int unsigned gap_max   = 0;

    initial begin
        wr_ack  = 1'b0;
        wr_take = 1'b0;
        forever begin
            tick();
            if (!rst && wr_req) begin
                repeat (ack_delay) tick();
                wr_ack = 1'b1;
                tick();
                wr_ack = 1'b0;
                for (int i = 0; i < BL; i++) begin
                    if (rst) break;
                    if (gap_max > 0) repeat ($urandom_range(gap_max, gap_min)) tick();
                    if (rst) break;
                    wr_take = 1'b1;
                    tick();
                    wr_take = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor
    int            bursts_done = 0;
    int            widx        = 0;
    int            bpops       = 0;
    logic          prev_req    = 1'b0;
    logic [AW-1:0] cur_addr    = '0;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            widx     = 0;
            bpops    = 0;
            prev_req = 1'b0;
        end else begin
            if (sync_err) begin
                if (exp_se.size() == 0) chk("sync_err_unexpected", sync_err, 0);
                else chk("sync_err_pos", bursts_done * 1024 + widx, exp_se.pop_front());
            end
            if (frame_done) begin
                if (exp_fd.size() == 0) chk("frame_done_unexpected", frame_done, 0);
                else chk("frame_done_burst", bursts_done, exp_fd.pop_front());
            end
            if (wr_req) begin
                if (!prev_req) begin
                    if (exp_addr.size() == 0) chk("wr_req_unexpected", wr_req, 0);
                    else begin
                        cur_addr = exp_addr.pop_front();
                        chk("wr_addr", wr_addr, cur_addr);
                    end
                end else begin
                    chk("wr_addr_stable", wr_addr, cur_addr);
                end
            end
            prev_req = wr_req;
            if (wr_take && busy && !wr_req) begin
                if (exp_data.size() == 0) chk("wr_data_unexpected", wr_take, 0);
                else chk("wr_data", wr_data, exp_data.pop_front());
                chk("rd_fifo_on_take", rd_fifo, (widx != BL - 1));
                widx++;
                if (widx == BL) begin
                    chk("pops_per_burst", bpops, BL);
                    bursts_done++;
                    widx  = 0;
                    bpops = 0;
                end
            end
            if (rd_fifo) bpops++;
        end
    end

    task automatic wait_bursts(input int n);
        int cyc = 0;
        while (bursts_done < n && cyc < 4000) begin
            tick();
            cyc++;
        end
        chk("bursts_done", bursts_done, n);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_fifo"}, rd_fifo, 0);
        chk({tag, "_wr_req"}, wr_req, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_sync_err"}, sync_err, 0);
        chk({tag, "_wr_addr"}, wr_addr, BASE);
    endtask

    // ---------------- stimulus
    initial begin
        int cyc;
        enable = 1'b1;
        #1 rst = 1'b1;
        #1 chk_reset_outputs("reset");
        repeat (3) tick();
        rst = 1'b0;

        // 255 words buffered: must not start
        for (int i = 0; i < BL - 1; i++) push_word(i == 0);
        repeat (10) begin
            tick();
            chk("no_pop_at_255", rd_fifo, 0);
            chk("no_busy_at_255", busy, 0);
        end
        // 256th word: pop now, wr_req two cycles later
        exp_addr.push_back(BASE);
        push_word(1'b0);
        #1;
        chk("start_pop", rd_fifo, 1);
        chk("start_no_req", wr_req, 0);
        tick();
        chk("prime_no_pop", rd_fifo, 0);
        chk("prime_no_req", wr_req, 0);
        tick();
        chk("req_after_2", wr_req, 1);
        wait_bursts(1);

        // second burst continues the frame
        push_burst(-1, BASE + 24'd256);
        wait_bursts(2);

        // delayed grant and irregular takes
        ack_delay = 7; gap_min = 1; gap_max = 5;
        push_burst(-1, BASE + 24'd512);
        wait_bursts(3);
        ack_delay = 0; gap_min = 0; gap_max = 0;

        // rest of frame 1 and all of frame 2 (SOF on burst 9 word 0)
        for (int k = 4; k <= 16; k++) begin
            push_burst((k == 9) ? 0 : -1, BASE + AW'(((k - 1) % 8) * BL));
            if (k % 8 == 0) exp_fd.push_back(k);
            if (k >= 5) wait_bursts(k - 1);
        end
        // burst 17 wraps on offset alone; burst 18 carries a stray SOF at word 37
        push_burst(-1, BASE);
        push_burst(37, BASE + 24'd256);
        exp_se.push_back(17 * 1024 + 38);
        wait_bursts(17);
        push_burst(-1, BASE);          // forced realign
        wait_bursts(19);

        // enable dropped while a request is pending
        ack_delay = 5;
        push_burst(-1, BASE + 24'd256);
        push_burst(-1, BASE + 24'd512);
        cyc = 0;
        while (!wr_req && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("req_before_disable", wr_req, 1);
        enable = 1'b0;
        wait_bursts(20);
        ack_delay = 0;
        repeat (20) begin
            tick();
            chk("disabled_busy", busy, 0);
            chk("disabled_pop", rd_fifo, 0);
        end
        enable = 1'b1;
        wait_bursts(21);

        // reset in the middle of a burst
        push_burst(-1, BASE + 24'd768);
        cyc = 0;
        while (!(bursts_done == 21 && widx == 100) && cyc < 2000) begin
            tick();
            cyc++;
        end
        chk("reached_word_100", widx, 100);
        rst = 1'b1;
        #1 chk_reset_outputs("mid_burst_reset");
        fifo_flush = 1'b1;
        exp_data.delete();
        tick();
        fifo_flush = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        push_burst(-1, BASE);
        wait_bursts(22);

        repeat (5) tick();
        chk("addr_queue_drained", exp_addr.size(), 0);
        chk("data_queue_drained", exp_data.size(), 0);
        chk("frame_done_seen", exp_fd.size(), 0);
        chk("sync_err_seen", exp_se.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sobel_fifo_sdram_writer.md
Name: sobel_fifo_sdram_writer

Overview:
Read-side consumer of the Sobel output FIFO (17-bit words, 1024 deep). It runs in the SDRAM clock domain and watches the FIFO read-side count. When a full burst is buffered, it pops the words and hands them to the SDRAM controller as fixed-length write bursts into a linear frame buffer. It realigns the frame address on the start-of-frame flag (bit 16 of each FIFO word) and reports frame completion and sync errors.

Parameters:
BURST_LEN, 256, words per SDRAM write burst (power of 2, at most 512, divides FRAME_WORDS)
FRAME_WORDS, 307200, pixels per frame (640x480)
ADDR_WIDTH, 24, SDRAM word-address width
FRAME_BASE, 0, word address of pixel 0 of the frame buffer

Ports:
clk  in  1  SDRAM-domain clock; also the FIFO read clock
rst  in  1  asynchronous, active-high reset
enable  in  1  permits new bursts to start; a burst already in progress always completes
data_count_r  in  10  FIFO read-side occupancy; excludes words already popped
fifo_dout  in  17  FIFO data; bit 16 = start-of-frame, bits 15:0 = pixel; valid the cycle after rd_fifo and held until the next pop
rd_fifo  out  1  FIFO pop strobe
wr_req  out  1  burst request to the SDRAM controller
wr_ack  in  1  one-cycle grant for the pending request
wr_addr  out  ADDR_WIDTH  burst start address; stable while wr_req=1
wr_take  in  1  controller consumes wr_data this cycle
wr_data  out  16  combinational copy of fifo_dout[15:0]
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse after the last word of a frame is taken
sync_err  out  1  one-cycle pulse on a start-of-frame flag that is not at word 0 of a burst

Behaviour:
- Reset (async, any state) forces: state=IDLE, offset=0, word_cnt=0, and rd_fifo, wr_req, busy, frame_done, sync_err all 0, wr_addr=FRAME_BASE. Reset during BURST abandons the burst. The controller must be reset together with this block.
- FSM states: IDLE, PRIME, REQ, BURST.
- IDLE: when enable=1 and data_count_r >= BURST_LEN, assert rd_fifo for one cycle and go to PRIME.
- PRIME (1 cycle): fifo_dout now holds word 0 of the burst.
  - If bit16=1, or offset=FRAME_WORDS, set offset to 0.
  - Latch wr_addr = FRAME_BASE + offset.
  - Go to REQ.
- REQ: hold wr_req=1 with a stable wr_addr. wr_ack may arrive in the first REQ cycle or any later one. On wr_ack, wr_req drops in the next cycle and the FSM enters BURST with word_cnt=0.
- BURST: on each wr_take, increment word_cnt.
  - If word_cnt < BURST_LEN-1, assert rd_fifo in the same cycle (combinational), so the next word is on fifo_dout one cycle later. Back-to-back takes every cycle are supported.
  - On the take with word_cnt = BURST_LEN-1: no pop; offset += BURST_LEN; go to IDLE.
  - If the new offset = FRAME_WORDS, pulse frame_done in the next cycle. The wrap to 0 happens at the next PRIME.
- Total pops per burst = BURST_LEN exactly, so the FIFO count stays consistent.
- wr_take outside BURST is ignored. wr_ack outside REQ is ignored.
- A start-of-frame flag seen on fifo_dout in BURST at word_cnt != 0 produces:
  - a sync_err pulse;
  - data still written sequentially;
  - the next burst starts at FRAME_BASE (forced realign); the partial frame is discarded logically.
- enable low during REQ/BURST: the burst finishes and the FSM stays in IDLE afterwards.
- Minimum time between bursts is 1 idle cycle: IDLE→PRIME→REQ gives a 2-cycle latency from the start decision to wr_req.
- Arithmetic: offset is ADDR_WIDTH bits, unsigned. word_cnt is log2(BURST_LEN) bits. The compare is >=, so any count from BURST_LEN to 1023 starts a burst.

Decomposition:
- Shared package (sdram_pkg) holds:
  - the state enum (IDLE/PRIME/REQ/BURST);
  - the SOF_BIT=16 constant;
  - the default FRAME_WORDS/BURST_LEN constants shared with the SDRAM read-back block.
- One natural sub-module, frame_addr_gen: offset counter with advance, wrap, SOF/forced realign, and frame_done generation. The FSM stays in the top.

Test Plan:
- Count 255 with enable=1 → no rd_fifo and no wr_req. Raise the count to 256 → rd_fifo for 1 cycle, wr_req 2 cycles later, wr_addr=FRAME_BASE.
- wr_ack in the first REQ cycle, then 256 consecutive wr_take with FIFO words 0..255 → exactly 256 rd_fifo pulses, wr_data sequence 0..255, return to IDLE, next wr_addr=256.
- Random wr_take gaps (1–5 cycles) plus a wr_ack delayed 7 cycles → wr_addr constant throughout REQ, no extra pops, data order preserved.
- Stream 1200 bursts, with the SOF flag on the first word only → frame_done pulses once after burst 1200, burst 1201 uses wr_addr=FRAME_BASE, no sync_err.
- SOF flag on word 37 of burst 5 → sync_err pulse at that word, burst 6 wr_addr=FRAME_BASE.
- Assert rst in BURST at word 100 → all outputs 0 immediately. After release with count >= 256, a new burst starts at FRAME_BASE.
